// File: rtl/mul_wb_pkg.sv
// -----------------------------------------------------------------------------
// mul_wb_pkg
//   Shared definitions between the pipelined multiplier and its writeback
//   tracker (mul_wb). The multiplier and the tracker must agree on MUL_LAT,
//   otherwise captured results would be paired with the wrong tag.
//
//   Contents:
//     ARCH_BITS      processor data width (width of resH/resL)
//     REG_BITS       architectural register address width
//     MUL_LAT        multiplier latency, accepted issue -> valid output
//     FIFO_DEPTH     default result buffer depth (also the credit count)
//     mul_tag_t      {valid, dest, hi} tag carried alongside a multiply
//     fifo_ptr_bits  pointer width (index width + 1 wrap bit) for a depth
// -----------------------------------------------------------------------------
package mul_wb_pkg;

  localparam int ARCH_BITS  = 32;
  localparam int REG_BITS   = 5;
  localparam int MUL_LAT    = 5;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] dest;
    logic                hi;
  } mul_tag_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index parts are equal.
  function automatic int fifo_ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mul_wb_fifo.sv
// -----------------------------------------------------------------------------
// mul_wb_fifo
//   Small circular result buffer. Read/write pointers are one bit wider than
//   the index; full/empty come from the wrap-bit compare. Push and pop in the
//   same cycle are both honoured, also when full (the pop frees the slot that
//   the push writes). Storage is not reset; only the pointers are.
//
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset (pointers only)
//     clear  in   synchronous flush, empties the buffer at the next edge
//     push   in   write wdata at the tail
//     wdata  in   WIDTH-bit entry to write
//     pop    in   advance the head (ignored when empty)
//     rdata  out  head entry (undefined contents when empty)
//     full   out  DEPTH entries held
//     empty  out  no entries held
// -----------------------------------------------------------------------------
module mul_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  import mul_wb_pkg::*;

  localparam int PTR_W = fifo_ptr_bits(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle releases the slot, so a push into a full buffer
  // is still safe when paired with a pop.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{IDX_W{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{IDX_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: rtl/mul_wb.sv
// -----------------------------------------------------------------------------
// mul_wb
//   Writeback tracker and result buffer for the pipelined multiplier.
//   Each accepted issue puts {dest, hi} into a MUL_LAT-deep tag pipe that
//   shifts in lockstep with the (non-stalling) multiplier. When the last tag
//   stage is valid, resH or resL is selected and pushed with its destination
//   into a FIFO that the writeback arbiter drains. An occupancy credit
//   (in-flight + buffered results) throttles issue so the FIFO never
//   overflows.
//
//   Build option:
//     MUL_WB_BYPASS_EN  when defined, a capture into an empty FIFO is shown on
//                       the wb_* outputs in the same cycle and, if granted,
//                       consumed without being pushed. When undefined every
//                       result goes through the FIFO and outputs come only
//                       from registered state.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     issue_valid/issue_ready  issue handshake from decode
//     issue_dest, issue_hi     destination register, high-half select
//     flush                    discard all in-flight and buffered results
//     resH, resL               multiplier outputs
//     wb_valid/wb_ready        writeback handshake (pop on valid && ready)
//     wb_dest, wb_data         head result; zero when nothing is available
// -----------------------------------------------------------------------------
module mul_wb #(
  parameter int ARCH_BITS  = mul_wb_pkg::ARCH_BITS,
  parameter int REG_BITS   = mul_wb_pkg::REG_BITS,
  parameter int MUL_LAT    = mul_wb_pkg::MUL_LAT,
  parameter int FIFO_DEPTH = mul_wb_pkg::FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_BITS-1:0]  issue_dest,
  input  logic                 issue_hi,
  input  logic                 flush,
  input  logic [ARCH_BITS-1:0] resH,
  input  logic [ARCH_BITS-1:0] resL,
  output logic                 wb_valid,
  output logic [REG_BITS-1:0]  wb_dest,
  output logic [ARCH_BITS-1:0] wb_data,
  input  logic                 wb_ready
);
  import mul_wb_pkg::*;

  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = REG_BITS + ARCH_BITS;

  function automatic logic [ARCH_BITS-1:0] sel_result(
    input logic                 hi,
    input logic [ARCH_BITS-1:0] h,
    input logic [ARCH_BITS-1:0] l
  );
    return hi ? h : l;
  endfunction

  logic                 accept;
  logic                 wb_pop;
  logic [OCC_W-1:0]     occ_q, occ_d;

  // Tag pipe: valid bits are control and get cleared; dest/hi payload just
  // follows along and is only looked at when its valid bit is set.
  logic [MUL_LAT-1:0]   vld_pipe_q;
  logic [REG_BITS-1:0]  dest_pipe_q [MUL_LAT];
  logic [MUL_LAT-1:0]   hi_pipe_q;

  logic                 cap;
  logic [REG_BITS-1:0]  cap_dest;
  logic [ARCH_BITS-1:0] cap_data;
  logic                 byp;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;

  // ---- issue / credit -------------------------------------------------------
  assign issue_ready = (occ_q != OCC_W'(FIFO_DEPTH)) && !flush && !rst;
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    occ_d = occ_q;
    if (accept && !wb_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && wb_pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // ---- tag pipe stages 0..MUL_LAT-1 -----------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= accept;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dest_pipe_q[0] <= issue_dest;
    hi_pipe_q[0]   <= issue_hi;
    for (int i = 1; i < MUL_LAT; i++) begin
      dest_pipe_q[i] <= dest_pipe_q[i-1];
      hi_pipe_q[i]   <= hi_pipe_q[i-1];
    end
  end

  // ---- capture at the multiplier output -------------------------------------
  assign cap      = vld_pipe_q[MUL_LAT-1];
  assign cap_dest = dest_pipe_q[MUL_LAT-1];
  assign cap_data = sel_result(hi_pipe_q[MUL_LAT-1], resH, resL);

`ifdef MUL_WB_BYPASS_EN
  assign byp = cap && fifo_empty;
`else
  assign byp = 1'b0;
`endif

  // A bypassed result that is granted immediately never enters the FIFO.
  assign fifo_push = cap && !(byp && wb_ready);
  assign fifo_pop  = wb_ready && !fifo_empty;

  mul_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (fifo_push),
    .wdata ({cap_dest, cap_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---- writeback outputs ----------------------------------------------------
  always_comb begin
    wb_valid = 1'b0;
    wb_dest  = '0;
    wb_data  = '0;
    if (!fifo_empty) begin
      wb_valid           = 1'b1;
      {wb_dest, wb_data} = fifo_rdata;
    end else if (byp) begin
      wb_valid = 1'b1;
      wb_dest  = cap_dest;
      wb_data  = cap_data;
    end
  end

  assign wb_pop = wb_valid && wb_ready;

  // The credit counter makes this unreachable; it guards against a
  // multiplier/tracker latency mismatch or a broken credit path.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_mul_wb.sv
module tb_mul_wb;

  localparam int AB = 32;
  localparam int RB = 5;
`ifdef MUL_WB_BYPASS_EN
  localparam int WB_LAT = 5;
`else
  localparam int WB_LAT = 6;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [RB-1:0] issue_dest = '0;
  logic          issue_hi = 1'b0;
  logic          flush = 1'b0;
  logic [AB-1:0] resH, resL;
  logic          wb_valid;
  logic [RB-1:0] wb_dest;
  logic [AB-1:0] wb_data;
  logic          wb_ready = 1'b0;

  logic [31:0]   op_a = '0;
  logic [31:0]   op_b = '0;
  logic [63:0]   prod_q [5];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Five-stage unsigned multiplier model, no stall, no reset on data.
  always @(posedge clk) begin
    prod_q[0] <= {32'd0, op_a} * {32'd0, op_b};
    for (int i = 1; i < 5; i++) prod_q[i] <= prod_q[i-1];
  end
  assign resH = prod_q[4][63:32];
  assign resL = prod_q[4][31:0];

  mul_wb dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_dest  (issue_dest),
    .issue_hi    (issue_hi),
    .flush       (flush),
    .resH        (resH),
    .resL        (resL),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_issue(input logic [RB-1:0] d, input logic h, input logic [31:0] a,
                           input logic [31:0] b);
    issue_valid = 1'b1;
    issue_dest  = d;
    issue_hi    = h;
    op_a        = a;
    op_b        = b;
  endtask

  // Issue one multiply, then measure cycles until wb_valid and check the result.
  task automatic single(input string tag, input logic [RB-1:0] d, input logic h,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_data);
    int lat;
    wb_ready = 1'b1;
    set_issue(d, h, a, b);
    #1;
    chk({tag, "_accept"}, issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    #1;
    lat = 1;
    while (!wb_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, WB_LAT);
    chk({tag, "_vld"}, wb_valid, 1);
    chk({tag, "_dest"}, wb_dest, d);
    chk({tag, "_data"}, wb_data, exp_data);
    tick();
    chk({tag, "_gone"}, wb_valid, 0);
  endtask

  // Wait (bounded) for the next result, check it; wb_ready must be high.
  task automatic expect_wb(input string tag, input logic [RB-1:0] d, input logic [31:0] v);
    int n = 0;
    while (!wb_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, wb_valid, 1);
    chk({tag, "_dest"}, wb_dest, d);
    chk({tag, "_data"}, wb_data, v);
    tick();
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_ready", issue_ready, 0);
    chk("rst_vld", wb_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", issue_ready, 1);
    chk("post_rst_vld", wb_valid, 0);
    chk("post_rst_dest", wb_dest, 0);
    chk("post_rst_data", wb_data, 0);
    tick();

    // Single MUL and MULH
    single("mul", 5'd3, 1'b0, 32'd7, 32'd6, 32'd42);
    single("mulh", 5'd9, 1'b1, 32'h8000_0000, 32'd4, 32'd2);

    // Backpressure: only FIFO_DEPTH issues accepted, then in-order drain
    wb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_issue(RB'(i + 1), 1'b0, 32'(i + 1), 32'd10);
      #1;
      chk($sformatf("bp_ready%0d", i), issue_ready, (i < 4) ? 1 : 0);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("bp_full_vld", wb_valid, 1);
    chk("bp_full_dest", wb_dest, 1);
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_drain_vld%0d", k), wb_valid, 1);
      chk($sformatf("bp_drain_dest%0d", k), wb_dest, k + 1);
      chk($sformatf("bp_drain_data%0d", k), wb_data, 10 * (k + 1));
      chk($sformatf("bp_drain_ready%0d", k), issue_ready, (k != 0) ? 1 : 0);
      tick();
    end
    chk("bp_empty", wb_valid, 0);

    // Capture and pop together at full occupancy, issue and pop together
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_issue(RB'(11 + i), 1'b0, 32'(i + 2), 32'd3);
      #1;
      chk($sformatf("ov_ready%0d", i), issue_ready, 1);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("ov_head_vld", wb_valid, 1);
    chk("ov_head_dest", wb_dest, 11);
    chk("ov_head_data", wb_data, 6);
    wb_ready = 1'b1;
    #1;
    chk("ov_occ4_ready", issue_ready, 0);
    tick();
    set_issue(5'd15, 1'b0, 32'd5, 32'd5);
    #1;
    chk("ov_e_accept", issue_ready, 1);
    chk("ov_b_dest", wb_dest, 12);
    tick();
    set_issue(5'd16, 1'b0, 32'd6, 32'd6);
    wb_ready = 1'b0;
    #1;
    chk("ov_f_accept", issue_ready, 1);
    chk("ov_c_dest", wb_dest, 13);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("ov_refull_ready", issue_ready, 0);
    wb_ready = 1'b1;
    expect_wb("ov_c", 5'd13, 32'd12);
    expect_wb("ov_d", 5'd14, 32'd15);
    expect_wb("ov_e", 5'd15, 32'd25);
    expect_wb("ov_f", 5'd16, 32'd36);

    // Flush with two buffered and two in flight
    tick();
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_issue(RB'(21 + i), 1'b0, 32'(i + 1), 32'd1);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("fl_pre_vld", wb_valid, 1);
    chk("fl_pre_dest", wb_dest, 21);
    flush = 1'b1;
    #1;
    chk("fl_ready_low", issue_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_vld", wb_valid, 0);
    chk("fl_data", wb_data, 0);
    chk("fl_ready", issue_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fl_stale%0d", i), wb_valid, 0);
    end

    // Reset mid-stream for one cycle
    set_issue(5'd5, 1'b0, 32'd2, 32'd2);
    tick();
    set_issue(5'd6, 1'b0, 32'd3, 32'd3);
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("mr_pre_vld", wb_valid, 1);
    chk("mr_pre_dest", wb_dest, 5);
    rst = 1'b1;
    #1;
    chk("mr_rst_ready", issue_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_vld", wb_valid, 0);
    chk("mr_dest", wb_dest, 0);
    chk("mr_data", wb_data, 0);
    chk("mr_ready", issue_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mr_stale%0d", i), wb_valid, 0);
    end
    single("mr_new", 5'd7, 1'b0, 32'd12, 32'd12, 32'd144);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
